// File: rtl/rv32i_if_id_top.sv
// RV32I fetch + decode front end: PC, instruction ROM, IF/ID register, register file,
// immediate/control decode and the ID/EX pipeline register.
module rv32i_if_id_top #(
    // Program image (the contents of imem.hex); words not listed read as addi x0,x0,0
    parameter logic [31:0] RomImage [256] = '{default: 32'h0000_0013}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCtarget,
    input  logic        WB_ID_WE3,
    input  logic [4:0]  WB_ID_RD_A3,
    input  logic [31:0] WB_ID_WD3,
    output logic [31:0] ID_EX_A,
    output logic [31:0] ID_EX_B,
    output logic [31:0] ID_EX_IMM,
    output logic [31:0] ID_EX_PC,
    output logic [4:0]  ID_EX_RD,
    output logic [2:0]  alucontrol,
    output logic [6:0]  alucontrol7,
    output logic [1:0]  alu_type_sel,
    output logic        branch,
    output logic        jump,
    output logic        memwrite_en,
    output logic        regwrite_en,
    output logic        wb_sel,
    output logic        b_imm_sel
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  alucontrol;
        logic [6:0]  alucontrol7;
        logic [1:0]  alu_type_sel;
        logic        branch;
        logic        jump;
        logic        memwrite_en;
        logic        regwrite_en;
        logic        wb_sel;
        logic        b_imm_sel;
    } idex_t;

    // ---------------- fetch ----------------
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr;

    assign instr = RomImage[pc_q[9:2]];

    always_comb begin
        pc_d = PCSrcE ? PCtarget : pc_q + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // ---------------- IF/ID ----------------
    logic [31:0] ir_q, ir_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;

    always_comb begin
        ir_d      = PCSrcE ? Nop : instr;
        ifid_pc_d = pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q      <= Nop;
            ifid_pc_q <= '0;
        end else begin
            ir_q      <= ir_d;
            ifid_pc_q <= ifid_pc_d;
        end
    end

    // ---------------- register file ----------------
    logic [31:0] regs_q [32];
    logic        wb_wr;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data, rs2_data;

    assign wb_wr = WB_ID_WE3 && (WB_ID_RD_A3 != 5'd0);
    assign rs1   = ir_q[19:15];
    assign rs2   = ir_q[24:20];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_wr) begin
            regs_q[WB_ID_RD_A3] <= WB_ID_WD3;
        end
    end

    // Same-cycle WB bypass so decode never sees a stale value being written
    always_comb begin
        if (rs1 == 5'd0) begin
            rs1_data = '0;
        end else if (wb_wr && (WB_ID_RD_A3 == rs1)) begin
            rs1_data = WB_ID_WD3;
        end else begin
            rs1_data = regs_q[rs1];
        end
        if (rs2 == 5'd0) begin
            rs2_data = '0;
        end else if (wb_wr && (WB_ID_RD_A3 == rs2)) begin
            rs2_data = WB_ID_WD3;
        end else begin
            rs2_data = regs_q[rs2];
        end
    end

    // ---------------- decode ----------------
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic        dec_regwrite, dec_memwrite, dec_wb_sel, dec_branch, dec_jump, dec_b_imm;
    logic [1:0]  dec_alu_type;
    logic [2:0]  dec_alucontrol;
    logic [6:0]  dec_alucontrol7;
    logic [31:0] dec_a;

    assign opcode = ir_q[6:0];

    always_comb begin
        dec_regwrite    = 1'b0;
        dec_memwrite    = 1'b0;
        dec_wb_sel      = 1'b0;
        dec_branch      = 1'b0;
        dec_jump        = 1'b0;
        dec_b_imm       = 1'b0;
        dec_alu_type    = 2'b00;
        dec_alucontrol  = 3'b000;
        dec_alucontrol7 = 7'b0;
        imm             = '0;
        dec_a           = rs1_data;
        unique case (opcode)
            OpR: begin
                dec_regwrite    = 1'b1;
                dec_alucontrol  = ir_q[14:12];
                dec_alucontrol7 = ir_q[31:25];
            end
            OpImm: begin
                dec_regwrite    = 1'b1;
                dec_b_imm       = 1'b1;
                dec_alu_type    = 2'b01;
                dec_alucontrol  = ir_q[14:12];
                dec_alucontrol7 = ir_q[31:25];
                imm             = {{20{ir_q[31]}}, ir_q[31:20]};
            end
            OpLoad: begin
                dec_regwrite = 1'b1;
                dec_wb_sel   = 1'b1;
                dec_b_imm    = 1'b1;
                dec_alu_type = 2'b10;
                imm          = {{20{ir_q[31]}}, ir_q[31:20]};
            end
            OpStore: begin
                dec_memwrite = 1'b1;
                dec_b_imm    = 1'b1;
                dec_alu_type = 2'b10;
                imm          = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            end
            OpBranch: begin
                dec_branch     = 1'b1;
                dec_alu_type   = 2'b11;
                dec_alucontrol = ir_q[14:12];
                imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            end
            OpJal: begin
                dec_regwrite = 1'b1;
                dec_jump     = 1'b1;
                dec_b_imm    = 1'b1;
                dec_alu_type = 2'b10;
                imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            end
            OpJalr: begin
                dec_regwrite = 1'b1;
                dec_jump     = 1'b1;
                dec_b_imm    = 1'b1;
                dec_alu_type = 2'b10;
                imm          = {{20{ir_q[31]}}, ir_q[31:20]};
            end
            OpLui: begin
                dec_regwrite = 1'b1;
                dec_b_imm    = 1'b1;
                dec_alu_type = 2'b01;
                imm          = {ir_q[31:12], 12'b0};
                dec_a        = '0;
            end
            OpAuipc: begin
                dec_regwrite = 1'b1;
                dec_b_imm    = 1'b1;
                dec_alu_type = 2'b01;
                imm          = {ir_q[31:12], 12'b0};
                dec_a        = ifid_pc_q;
            end
            default: begin
            end
        endcase
    end

    // ---------------- ID/EX ----------------
    idex_t idex_q, idex_d;

    always_comb begin
        idex_d = '0;
        if (!PCSrcE) begin
            idex_d.a            = dec_a;
            idex_d.b            = rs2_data;
            idex_d.imm          = imm;
            idex_d.pc           = ifid_pc_q;
            idex_d.rd           = ir_q[11:7];
            idex_d.alucontrol   = dec_alucontrol;
            idex_d.alucontrol7  = dec_alucontrol7;
            idex_d.alu_type_sel = dec_alu_type;
            idex_d.branch       = dec_branch;
            idex_d.jump         = dec_jump;
            idex_d.memwrite_en  = dec_memwrite;
            idex_d.regwrite_en  = dec_regwrite;
            idex_d.wb_sel       = dec_wb_sel;
            idex_d.b_imm_sel    = dec_b_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ID_EX_A      = idex_q.a;
    assign ID_EX_B      = idex_q.b;
    assign ID_EX_IMM    = idex_q.imm;
    assign ID_EX_PC     = idex_q.pc;
    assign ID_EX_RD     = idex_q.rd;
    assign alucontrol   = idex_q.alucontrol;
    assign alucontrol7  = idex_q.alucontrol7;
    assign alu_type_sel = idex_q.alu_type_sel;
    assign branch       = idex_q.branch;
    assign jump         = idex_q.jump;
    assign memwrite_en  = idex_q.memwrite_en;
    assign regwrite_en  = idex_q.regwrite_en;
    assign wb_sel       = idex_q.wb_sel;
    assign b_imm_sel    = idex_q.b_imm_sel;

endmodule

// File: tb/tb_rv32i_if_id_top.sv
// Directed bench for rv32i_if_id_top: a short hand-encoded program with hand-computed
// decode results, plus WB bypass, x0, redirect and asynchronous reset scenarios.
module tb_rv32i_if_id_top;

    localparam logic [31:0] PROG [256] = '{
        0:  32'h0050_0093,  // addi x1,x0,5
        1:  32'h0021_01B3,  // add  x3,x2,x2
        2:  32'h0050_0093,  // addi x1,x0,5
        3:  32'h0001_0233,  // add  x4,x2,x0
        4:  32'hFE00_0CE3,  // beq  x0,x0,-8
        5:  32'hFE20_AE23,  // sw   x2,-4(x1)
        6:  32'h1234_52B7,  // lui  x5,0x12345
        7:  32'h0000_1317,  // auipc x6,1
        8:  32'h0100_00EF,  // jal  x1,16
        9:  32'h0041_2403,  // lw   x8,4(x2)
        10: 32'hFFFF_FFFF,  // unknown opcode
        16: 32'hFFF1_0393,  // addi x7,x2,-1
        default: 32'h0000_0013
    };

    logic        clk;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCtarget;
    logic        WB_ID_WE3;
    logic [4:0]  WB_ID_RD_A3;
    logic [31:0] WB_ID_WD3;
    logic [31:0] ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_PC;
    logic [4:0]  ID_EX_RD;
    logic [2:0]  alucontrol;
    logic [6:0]  alucontrol7;
    logic [1:0]  alu_type_sel;
    logic        branch, jump, memwrite_en, regwrite_en, wb_sel, b_imm_sel;

    int n_vec = 0;
    int n_err = 0;

    rv32i_if_id_top #(
        .RomImage(PROG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrcE      (PCSrcE),
        .PCtarget    (PCtarget),
        .WB_ID_WE3   (WB_ID_WE3),
        .WB_ID_RD_A3 (WB_ID_RD_A3),
        .WB_ID_WD3   (WB_ID_WD3),
        .ID_EX_A     (ID_EX_A),
        .ID_EX_B     (ID_EX_B),
        .ID_EX_IMM   (ID_EX_IMM),
        .ID_EX_PC    (ID_EX_PC),
        .ID_EX_RD    (ID_EX_RD),
        .alucontrol  (alucontrol),
        .alucontrol7 (alucontrol7),
        .alu_type_sel(alu_type_sel),
        .branch      (branch),
        .jump        (jump),
        .memwrite_en (memwrite_en),
        .regwrite_en (regwrite_en),
        .wb_sel      (wb_sel),
        .b_imm_sel   (b_imm_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {regwrite, memwrite, wb_sel, branch, jump, b_imm_sel, alu_type_sel}
    logic [7:0] ctrl;
    assign ctrl = {regwrite_en, memwrite_en, wb_sel, branch, jump, b_imm_sel, alu_type_sel};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"},    ID_EX_A, 32'h0);
        chk({tag, "_b"},    ID_EX_B, 32'h0);
        chk({tag, "_imm"},  ID_EX_IMM, 32'h0);
        chk({tag, "_pc"},   ID_EX_PC, 32'h0);
        chk({tag, "_rd"},   {27'h0, ID_EX_RD}, 32'h0);
        chk({tag, "_alu"},  {22'h0, alucontrol, alucontrol7}, 32'h0);
        chk({tag, "_ctrl"}, {24'h0, ctrl}, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        PCSrcE      = 1'b0;
        PCtarget    = '0;
        WB_ID_WE3   = 1'b0;
        WB_ID_RD_A3 = '0;
        WB_ID_WD3   = '0;
        repeat (2) @(negedge clk);
        chk_zero("in_rst");
        rst = 1'b0;
        chk_zero("rel");

        step();  // IF/ID <= addi; ID/EX holds the reset nop
        chk("nop_ctrl", {24'h0, ctrl}, 32'h85);
        step();
        chk("addi_imm",  ID_EX_IMM, 32'd5);
        chk("addi_rd",   {27'h0, ID_EX_RD}, 32'd1);
        chk("addi_pc",   ID_EX_PC, 32'h0);
        chk("addi_ctrl", {24'h0, ctrl}, 32'h85);
        chk("addi_f3",   {29'h0, alucontrol}, 32'h0);
        chk("addi_a",    ID_EX_A, 32'h0);

        WB_ID_WE3 = 1'b1; WB_ID_RD_A3 = 5'd2; WB_ID_WD3 = 32'h2;
        step();
        chk("byp_a",    ID_EX_A, 32'h2);
        chk("byp_b",    ID_EX_B, 32'h2);
        chk("byp_f7",   {25'h0, alucontrol7}, 32'h0);
        chk("byp_ctrl", {24'h0, ctrl}, 32'h80);
        chk("byp_rd",   {27'h0, ID_EX_RD}, 32'd3);
        chk("byp_pc",   ID_EX_PC, 32'h4);

        WB_ID_RD_A3 = 5'd0; WB_ID_WD3 = 32'hFFFF;
        step();
        chk("x0_a",  ID_EX_A, 32'h0);
        chk("x0_pc", ID_EX_PC, 32'h8);

        WB_ID_WE3 = 1'b0; WB_ID_WD3 = '0;
        step();  // add x4,x2,x0: x2 comes from the register array now
        chk("rf_a", ID_EX_A, 32'h2);
        chk("rf_b", ID_EX_B, 32'h0);

        step();
        chk("beq_imm",  ID_EX_IMM, 32'hFFFF_FFF8);
        chk("beq_ctrl", {24'h0, ctrl}, 32'h13);
        chk("beq_pc",   ID_EX_PC, 32'h10);

        step();
        chk("sw_imm",  ID_EX_IMM, 32'hFFFF_FFFC);
        chk("sw_ctrl", {24'h0, ctrl}, 32'h46);
        chk("sw_b",    ID_EX_B, 32'h2);
        chk("sw_alu",  {22'h0, alucontrol, alucontrol7}, 32'h0);

        step();
        chk("lui_imm",  ID_EX_IMM, 32'h1234_5000);
        chk("lui_a",    ID_EX_A, 32'h0);
        chk("lui_ctrl", {24'h0, ctrl}, 32'h85);
        chk("lui_alu",  {22'h0, alucontrol, alucontrol7}, 32'h0);

        step();
        chk("auipc_a",   ID_EX_A, 32'h1C);
        chk("auipc_imm", ID_EX_IMM, 32'h1000);

        step();
        chk("jal_imm",  ID_EX_IMM, 32'd16);
        chk("jal_ctrl", {24'h0, ctrl}, 32'h8E);
        chk("jal_pc",   ID_EX_PC, 32'h20);

        step();
        chk("lw_ctrl", {24'h0, ctrl}, 32'hA6);
        chk("lw_imm",  ID_EX_IMM, 32'd4);
        chk("lw_a",    ID_EX_A, 32'h2);

        step();
        chk("unk_ctrl", {24'h0, ctrl}, 32'h0);
        chk("unk_imm",  ID_EX_IMM, 32'h0);
        chk("unk_alu",  {22'h0, alucontrol, alucontrol7}, 32'h0);
        chk("unk_rd",   {27'h0, ID_EX_RD}, 32'd31);

        PCSrcE = 1'b1; PCtarget = 32'h40;
        step();
        chk_zero("flush");
        PCSrcE = 1'b0; PCtarget = '0;
        step();
        step();
        chk("redir_pc",  ID_EX_PC, 32'h40);
        chk("redir_imm", ID_EX_IMM, 32'hFFFF_FFFF);
        chk("redir_a",   ID_EX_A, 32'h2);
        chk("redir_f7",  {25'h0, alucontrol7}, 32'h7F);
        step();
        chk("redir_pc4", ID_EX_PC, 32'h44);
        chk("redir_nop", {24'h0, ctrl}, 32'h85);

        // Asynchronous reset in the middle of a cycle
        #2 rst = 1'b1;
        #1 chk_zero("arst");
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        chk("rst_pc",  ID_EX_PC, 32'h0);
        chk("rst_imm", ID_EX_IMM, 32'd5);
        step();
        chk("rst_pc4", ID_EX_PC, 32'h4);
        chk("rst_x2",  ID_EX_A, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
